// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: note masks, ROM entry layout,
// FSM state encoding and a built-in demo song used when no song image is supplied.
package song_pkg;

    localparam logic [7:0] NOTE_C  = 8'h01;
    localparam logic [7:0] NOTE_D  = 8'h02;
    localparam logic [7:0] NOTE_E  = 8'h04;
    localparam logic [7:0] NOTE_F  = 8'h08;
    localparam logic [7:0] NOTE_G  = 8'h10;
    localparam logic [7:0] NOTE_A  = 8'h20;
    localparam logic [7:0] NOTE_B  = 8'h40;
    localparam logic [7:0] NOTE_C2 = 8'h80;

    localparam logic [7:0] DUR_END = 8'd0;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] dur;
    } song_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic [15:0] make_entry(input logic [7:0] mask, input logic [7:0] dur);
        return {mask, dur};
    endfunction

    // Ascending scale; entry 0 sits in the low 16 bits, zero fill above acts as the end marker.
    localparam logic [127:0] DEMO_SONG = {
        make_entry(NOTE_C2, 8'd4), make_entry(NOTE_B, 8'd2),
        make_entry(NOTE_A,  8'd2), make_entry(NOTE_G, 8'd2),
        make_entry(NOTE_F,  8'd2), make_entry(NOTE_E, 8'd2),
        make_entry(NOTE_D,  8'd2), make_entry(NOTE_C, 8'd2)
    };

endpackage

// File: rtl/song_rom.sv
// Song ROM with registered read; the contents come from a packed parameter image
// (entry i at bits [16*i +: 16]) so each build can bake in its own song.
module song_rom #(
    parameter int                      SONG_LEN  = 64,
    parameter int                      ADDR_W    = 6,
    parameter logic [SONG_LEN*16-1:0]  SONG_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    logic [15:0] rom_mem [SONG_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < SONG_LEN; gi++) begin : g_entry
            assign rom_mem[gi] = SONG_INIT[gi*16 +: 16];
        end
    endgenerate

    always_ff @(posedge clk) begin
        data <= rom_mem[addr];
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM and drives the tone bank note lines, with a
// silent articulation gap between notes plus start/stop/pause/loop control.
module song_sequencer
    import song_pkg::*;
#(
    parameter int                      TICK_CYCLES = 3_125_000,
    parameter int                      GAP_TICKS   = 1,
    parameter int                      SONG_LEN    = 64,
    parameter int                      ADDR_W      = 6,
    parameter logic [SONG_LEN*16-1:0]  SONG_INIT   = (SONG_LEN*16)'(DEMO_SONG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [7:0]        line,
    output logic              playing,
    output logic              done,
    output logic [ADDR_W-1:0] note_idx
);

    localparam int PRESC_W = $clog2(TICK_CYCLES);
    localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    state_t              state_reg;
    logic [ADDR_W-1:0]   note_idx_reg;
    logic [PRESC_W-1:0]  presc_reg;
    logic [7:0]          dur_reg;
    logic [GAP_W-1:0]    gap_reg;
    logic [7:0]          mask_reg;
    logic [7:0]          line_reg;
    logic                load_wait_reg;
    logic                playing_reg;
    logic                done_reg;

    logic [15:0]         rom_data;
    song_entry_t         rom_entry;
    logic                counting;
    logic                tick;
    logic                last_idx;
    logic                note_finish;

    song_rom #(
        .SONG_LEN  (SONG_LEN),
        .ADDR_W    (ADDR_W),
        .SONG_INIT (SONG_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (note_idx_reg),
        .data (rom_data)
    );

    assign rom_entry = song_entry_t'(rom_data);
    assign counting  = ((state_reg == ST_PLAY) || (state_reg == ST_GAP)) && !pause;
    assign tick      = counting && (presc_reg == PRESC_LAST);
    assign last_idx  = (note_idx_reg == ADDR_W'(SONG_LEN - 1));

    // Last tick of a note's silent tail (or of the note itself when legato).
    assign note_finish = tick &&
        (((state_reg == ST_PLAY) && (dur_reg == 8'd1) && (GAP_TICKS == 0)) ||
         ((state_reg == ST_GAP) && (gap_reg <= GAP_W'(1))));

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            state_reg     <= ST_IDLE;
            note_idx_reg  <= '0;
            presc_reg     <= '0;
            dur_reg       <= '0;
            gap_reg       <= '0;
            mask_reg      <= '0;
            line_reg      <= '0;
            load_wait_reg <= 1'b0;
            playing_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (counting) begin
                presc_reg <= tick ? '0 : presc_reg + 1'b1;
            end

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg     <= ST_LOAD;
                        note_idx_reg  <= '0;
                        presc_reg     <= '0;
                        load_wait_reg <= 1'b1;
                        playing_reg   <= 1'b1;
                        done_reg      <= 1'b0;
                        line_reg      <= '0;
                    end
                end

                // First LOAD cycle only lets the ROM catch up with the new address.
                ST_LOAD: begin
                    if (!pause) begin
                        if (load_wait_reg) begin
                            load_wait_reg <= 1'b0;
                        end else if (rom_entry.dur == DUR_END) begin
                            if (loop_en) begin
                                note_idx_reg  <= '0;
                                load_wait_reg <= 1'b1;
                            end else begin
                                state_reg   <= ST_DONE;
                                playing_reg <= 1'b0;
                                done_reg    <= 1'b1;
                            end
                        end else begin
                            state_reg <= ST_PLAY;
                            dur_reg   <= rom_entry.dur;
                            mask_reg  <= rom_entry.mask;
                            line_reg  <= rom_entry.mask;
                        end
                    end
                end

                ST_PLAY: begin
                    if (pause) begin
                        line_reg <= '0;
                    end else begin
                        line_reg <= mask_reg;
                        if (tick) begin
                            if (dur_reg > 8'd1) begin
                                dur_reg <= dur_reg - 8'd1;
                            end else begin
                                dur_reg  <= '0;
                                line_reg <= '0;
                                if (GAP_TICKS != 0) begin
                                    state_reg <= ST_GAP;
                                    gap_reg   <= GAP_W'(GAP_TICKS);
                                end
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (tick && (gap_reg > GAP_W'(1))) begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (note_finish) begin
                if (last_idx) begin
                    if (loop_en) begin
                        state_reg     <= ST_LOAD;
                        note_idx_reg  <= '0;
                        presc_reg     <= '0;
                        load_wait_reg <= 1'b1;
                    end else begin
                        state_reg   <= ST_DONE;
                        playing_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end else begin
                    state_reg     <= ST_LOAD;
                    note_idx_reg  <= note_idx_reg + 1'b1;
                    presc_reg     <= '0;
                    load_wait_reg <= 1'b1;
                end
            end
        end
    end

    assign line     = line_reg;
    assign playing  = playing_reg;
    assign done     = done_reg;
    assign note_idx = note_idx_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two instances (terminated song and full-ROM song with a rest)
// share stimulus; expected note-line runs are queued and compared as the line changes.
module tb_song_sequencer;
    import song_pkg::*;

    localparam int TICK = 4;
    localparam int GAPT = 1;
    localparam int LEN  = 4;
    localparam int AW   = 2;

    localparam logic [63:0] SONG_A = {make_entry(8'h00, DUR_END), make_entry(NOTE_G, 8'd3),
                                      make_entry(NOTE_E, 8'd1), make_entry(NOTE_C, 8'd2)};
    localparam logic [63:0] SONG_B = {make_entry(NOTE_C2, 8'd1), make_entry(NOTE_B, 8'd1),
                                      make_entry(8'h00, 8'd2), make_entry(NOTE_A, 8'd1)};

    logic          clk = 1'b0;
    logic          rst, start, stop, pause, loop_en;
    logic [7:0]    line_a, line_b;
    logic          playing_a, playing_b, done_a, done_b;
    logic [AW-1:0] note_idx_a, note_idx_b;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] val;
        int         len;
    } run_t;
    run_t exp_q[$];

    always #5 clk = ~clk;

    song_sequencer #(.TICK_CYCLES(TICK), .GAP_TICKS(GAPT), .SONG_LEN(LEN), .ADDR_W(AW),
                     .SONG_INIT(SONG_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .line(line_a), .playing(playing_a), .done(done_a), .note_idx(note_idx_a)
    );

    song_sequencer #(.TICK_CYCLES(TICK), .GAP_TICKS(GAPT), .SONG_LEN(LEN), .ADDR_W(AW),
                     .SONG_INIT(SONG_B)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
        .line(line_b), .playing(playing_b), .done(done_b), .note_idx(note_idx_b)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests_run++;
        if (obs != exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] get_line(input bit sel);
        return sel ? line_b : line_a;
    endfunction

    task automatic push_run(input logic [7:0] v, input int n);
        run_t r;
        r.val = v;
        r.len = n;
        exp_q.push_back(r);
    endtask

    // Measures the run starting at the current negedge; returns on the first sample of the next run.
    task automatic run_len(input bit sel, output logic [7:0] v, output int n);
        v = get_line(sel);
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (get_line(sel) == v && n < 400);
    endtask

    task automatic drain(input bit sel);
        run_t       e;
        logic [7:0] v;
        int         n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            run_len(sel, v, n);
            $display("[TB] dut%0d run line=%02h cycles=%0d (want %02h x %0d)", sel, v, n, e.val, e.len);
            chk("run_line", int'(v), int'(e.val));
            chk("run_cycles", n, e.len);
        end
    endtask

    // Pulses start and waits for the first note; ends on that note's first sample.
    task automatic start_song(input bit sel);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (get_line(sel) == 8'h00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        $display("[TB] dut%0d start latency=%0d", sel, n);
        chk("start_latency", n, 3);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;

        // Reset with start held high
        repeat (2) @(negedge clk);
        chk("rst_line", int'(line_a), 0);
        chk("rst_playing", int'(playing_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_idx", int'(note_idx_a), 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", int'(playing_a), 0);

        // Basic song, with a start pulse mid-note that must be ignored
        start_song(0);
        push_run(NOTE_C, 2*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_E, 1*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_G, 3*TICK);
        fork
            begin
                repeat (2) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            drain(0);
        join
        chk("gap_playing", int'(playing_a), 1);
        repeat (5) @(negedge clk);
        chk("done_not_yet", int'(done_a), 0);
        @(negedge clk);
        chk("end_done", int'(done_a), 1);
        chk("end_playing", int'(playing_a), 0);
        chk("end_line", int'(line_a), 0);
        chk("end_idx", int'(note_idx_a), 3);

        // Loop from DONE, then stop+start collision during the second pass
        loop_en = 1'b1;
        start_song(0);
        push_run(NOTE_C, 2*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_E, 1*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_G, 3*TICK); push_run(8'h00, GAPT*TICK + 4);
        drain(0);
        chk("loop_line", int'(line_a), int'(NOTE_C));
        chk("loop_done", int'(done_a), 0);
        chk("loop_idx", int'(note_idx_a), 0);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        chk("stop_line", int'(line_a), 0);
        chk("stop_playing", int'(playing_a), 0);
        chk("stop_idx", int'(note_idx_a), 0);
        @(negedge clk);
        chk("stop_beats_start", int'(playing_a), 0);
        loop_en = 1'b0;

        // Pause for 10 cycles in the middle of the 3-tick G
        start_song(0);
        push_run(NOTE_C, 2*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_E, 1*TICK); push_run(8'h00, GAPT*TICK + 2);
        drain(0);
        push_run(NOTE_G, 4); push_run(8'h00, 10); push_run(NOTE_G, 3*TICK - 4);
        fork
            begin
                repeat (3) @(negedge clk);
                pause = 1'b1;
                repeat (5) @(negedge clk);
                chk("pause_idx", int'(note_idx_a), 2);
                chk("pause_playing", int'(playing_a), 1);
                repeat (5) @(negedge clk);
                pause = 1'b0;
            end
            drain(0);
        join
        repeat (6) @(negedge clk);
        chk("pause_song_done", int'(done_a), 1);

        // Full ROM with a rest and no end marker
        start_song(1);
        push_run(NOTE_A, 1*TICK);
        push_run(8'h00, (GAPT*TICK + 2) + 2*TICK + (GAPT*TICK + 2));
        push_run(NOTE_B, 1*TICK); push_run(8'h00, GAPT*TICK + 2);
        push_run(NOTE_C2, 1*TICK);
        drain(1);
        repeat (3) @(negedge clk);
        chk("full_done_not_yet", int'(done_b), 0);
        @(negedge clk);
        chk("full_done", int'(done_b), 1);
        chk("full_idx", int'(note_idx_b), 3);
        chk("full_playing", int'(playing_b), 0);
        chk("full_line", int'(line_b), 0);

        // Reset in the middle of a note
        start_song(0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_line", int'(line_a), 0);
        chk("midrst_playing", int'(playing_a), 0);
        chk("midrst_idx", int'(note_idx_a), 0);
        chk("midrst_done", int'(done_a), 0);
        repeat (2) @(negedge clk);
        chk("midrst_no_residual", int'(line_a), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
